// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: funct codes,
// FSM state encoding and the operation descriptor handed to the datapath.
package mult_div_ctrl_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } op_t;

  // MULT/MULTU/DIV/DIVU
  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  // Any instruction that touches HI/LO and therefore must wait on a busy unit
  function automatic logic is_hilo(input logic [5:0] funct);
    return is_muldiv(funct) ||
           (funct == FUNCT_MFHI) || (funct == FUNCT_MTHI) ||
           (funct == FUNCT_MFLO) || (funct == FUNCT_MTLO);
  endfunction

  function automatic op_t decode_op(input logic [5:0] funct);
    op_t op;
    op.is_div    = funct[1];
    op.is_signed = ~funct[0];
    return op;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// EX-stage <-> HI/LO unit handshake: issue side from decode, status and data back.
interface mult_div_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             issue_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic [WIDTH-1:0] mf_data_o;

  modport master (
    output issue_i, funct_i, rs_i, rt_i,
    input  busy_o, stall_o, done_o, hi_o, lo_o, mf_data_o
  );

  modport slave (
    input  issue_i, funct_i, rs_i, rt_i,
    output busy_o, stall_o, done_o, hi_o, lo_o, mf_data_o
  );

endinterface

// File: rtl/mult_div_ctrl_datapath.sv
// Magnitude shift-add multiplier / restoring divider with final sign fix.
// Sequenced by mult_div_ctrl; result outputs are valid while the FSM is in FIX.
module mult_div_ctrl_datapath
  import mult_div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             mul_step,
  input  logic             div_step,
  output logic [WIDTH-1:0] res_hi_c,
  output logic [WIDTH-1:0] res_lo_c
);

  localparam int unsigned ACC_W = 2 * WIDTH;

  logic [ACC_W-1:0] acc_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] rs_raw_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             div_zero_q;
  logic             is_div_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [ACC_W-1:0] div_next;

  logic [ACC_W-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign a_neg = op.is_signed & rs[WIDTH-1];
  assign b_neg = op.is_signed & rt[WIDTH-1];
  assign mag_a = a_neg ? (WIDTH'(0) - rs) : rs;
  assign mag_b = b_neg ? (WIDTH'(0) - rt) : rt;

  // Multiply: acc = {partial, multiplier}; add multiplicand into top half, shift right
  assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift in next dividend bit, trial subtract
  assign div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge};

  // Operand capture at accept, then one step per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      opb_q      <= '0;
      rs_raw_q   <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      is_div_q   <= 1'b0;
    end else if (start) begin
      acc_q      <= {WIDTH'(0), mag_a};
      opb_q      <= mag_b;
      rs_raw_q   <= rs;
      neg_res_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div_zero_q <= (rt == WIDTH'(0));
      is_div_q   <= op.is_div;
    end else if (mul_step) begin
      acc_q <= mul_next;
    end else if (div_step) begin
      acc_q <= div_next;
    end
  end

  assign prod = neg_res_q ? (ACC_W'(0) - acc_q) : acc_q;
  assign quo  = acc_q[WIDTH-1:0];
  assign rem  = acc_q[ACC_W-1:WIDTH];

  // Sign correction and divide-by-zero override
  always_comb begin
    res_hi_c = prod[ACC_W-1:WIDTH];
    res_lo_c = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi_c = rs_raw_q;
        res_lo_c = '1;
      end else begin
        res_hi_c = neg_rem_q ? (WIDTH'(0) - rem) : rem;
        res_lo_c = neg_res_q ? (WIDTH'(0) - quo) : quo;
      end
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: owns HI/LO, runs the
// iterative datapath and stalls HI/LO consumers while an operation is in flight.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             busy;
  logic             mul_step;
  logic             div_step;
  logic             fix_step;

  logic             idle;
  logic             accept_op;
  logic             accept_mthi;
  logic             accept_mtlo;
  logic             last_iter;
  op_t              op;
  logic [WIDTH-1:0] res_hi_c;
  logic [WIDTH-1:0] res_lo_c;

  assign idle        = (state_q == IDLE);
  assign accept_op   = bus.issue_i & idle & is_muldiv(bus.funct_i);
  assign accept_mthi = bus.issue_i & idle & (bus.funct_i == FUNCT_MTHI);
  assign accept_mtlo = bus.issue_i & idle & (bus.funct_i == FUNCT_MTLO);
  assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
  assign op          = decode_op(bus.funct_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_op) state_d = op.is_div ? DIV : MUL;
      MUL,
      DIV:     if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    mul_step = 1'b0;
    div_step = 1'b0;
    fix_step = 1'b0;
    unique case (state_q)
      IDLE:    ;
      MUL:     begin busy = 1'b1; mul_step = 1'b1; end
      DIV:     begin busy = 1'b1; div_step = 1'b1; end
      FIX:     begin busy = 1'b1; fix_step = 1'b1; end
      default: ;
    endcase
  end

  // Iteration counter, done pulse and HI/LO ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= fix_step;
      if (accept_op || fix_step)   cnt_q <= '0;
      else if (mul_step || div_step) cnt_q <= cnt_q + CNT_W'(1);
      if (fix_step) begin
        hi_q <= res_hi_c;
        lo_q <= res_lo_c;
      end else begin
        if (accept_mthi) hi_q <= bus.rs_i;
        if (accept_mtlo) lo_q <= bus.rs_i;
      end
    end
  end

  mult_div_ctrl_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept_op),
    .op       (op),
    .rs       (bus.rs_i),
    .rt       (bus.rt_i),
    .mul_step (mul_step),
    .div_step (div_step),
    .res_hi_c (res_hi_c),
    .res_lo_c (res_lo_c)
  );

  assign bus.busy_o    = busy;
  assign bus.done_o    = done_q;
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.stall_o   = bus.issue_i & busy & is_hilo(bus.funct_i);
  assign bus.mf_data_o = (bus.funct_i == FUNCT_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized scoreboard bench for mult_div_ctrl: driver pushes model results,
// a negedge monitor pops and compares whenever the DUT presents output.
module tb_mult_div_ctrl;
  import mult_div_ctrl_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  typedef struct {
    logic        is_hi;
    logic [31:0] val;
  } mt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  res_t        exp_q[$];
  logic [31:0] mf_q[$];
  mt_t         mt_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit is_known(input logic [5:0] f);
    return f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural operands
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sp;
    longint unsigned up;
    bit is_op;
    mt_t m;
    int n;
    is_op = 1'b1;
    r.hi = '0;
    r.lo = '0;
    case (f)
      FUNCT_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        r.hi = sp[63:32]; r.lo = sp[31:0];
      end
      FUNCT_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        r.hi = up[63:32]; r.lo = up[31:0];
      end
      FUNCT_DIV: begin
        if (b == 0) begin r.hi = a; r.lo = '1; end
        else begin
          sp = longint'($signed(a)) / longint'($signed(b)); r.lo = sp[31:0];
          sp = longint'($signed(a)) % longint'($signed(b)); r.hi = sp[31:0];
        end
      end
      FUNCT_DIVU: begin
        if (b == 0) begin r.hi = a; r.lo = '1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      default: is_op = 1'b0;
    endcase
    if (is_op) begin
      m_hi = r.hi; m_lo = r.lo;
      exp_q.push_back(r);
    end else if (f == FUNCT_MTHI) begin
      m_hi = a; m.is_hi = 1'b1; m.val = a; mt_q.push_back(m);
    end else if (f == FUNCT_MTLO) begin
      m_lo = a; m.is_hi = 1'b0; m.val = a; mt_q.push_back(m);
    end else if (f == FUNCT_MFHI) begin
      mf_q.push_back(m_hi);
    end else if (f == FUNCT_MFLO) begin
      mf_q.push_back(m_lo);
    end
    bus.issue_i = 1'b1;
    bus.funct_i = f;
    bus.rs_i    = a;
    bus.rt_i    = b;
    n = 0;
    @(negedge clk);
    while (bus.stall_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("issue_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    bus.issue_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy_o && n < 500) begin
      n++;
      @(posedge clk);
    end
    if (n >= 500) chk("idle_timeout", 64'(n), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  // Monitor / scoreboard
  logic prev_busy = 1'b0;
  int   busy_run  = 0;
  logic pend_busy = 1'b0;
  logic pend_mt   = 1'b0;
  mt_t  pend_mt_v;

  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_run  = 0;
      pend_busy = 1'b0;
      pend_mt   = 1'b0;
    end else begin
      if (bus.issue_i)
        chk("stall_rule", 64'(bus.stall_o), 64'(bus.busy_o & is_known(bus.funct_i)));
      if (pend_busy) chk("accept_busy", 64'(bus.busy_o), 64'(1));
      pend_busy = 1'b0;
      if (pend_mt) begin
        if (pend_mt_v.is_hi) chk("mthi_write", 64'(bus.hi_o), 64'(pend_mt_v.val));
        else                 chk("mtlo_write", 64'(bus.lo_o), 64'(pend_mt_v.val));
      end
      pend_mt = 1'b0;
      if (bus.done_o || (prev_busy && !bus.busy_o))
        chk("done_after_busy", 64'({bus.done_o, prev_busy & ~bus.busy_o}), 64'(2'b11));
      if (prev_busy && !bus.busy_o) chk("busy_len", 64'(busy_run), 64'(W + 1));
      if (bus.done_o) begin
        if (exp_q.size() == 0) chk("result_queue", 64'(exp_q.size()), 64'(1));
        else begin
          r = exp_q.pop_front();
          chk("result_hi", 64'(bus.hi_o), 64'(r.hi));
          chk("result_lo", 64'(bus.lo_o), 64'(r.lo));
        end
      end
      busy_run = bus.busy_o ? busy_run + 1 : 0;
      if (bus.issue_i && !bus.busy_o && is_known(bus.funct_i)) begin
        if (bus.funct_i inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU})
          pend_busy = 1'b1;
        else if (bus.funct_i inside {FUNCT_MTHI, FUNCT_MTLO}) begin
          if (mt_q.size() == 0) chk("mt_queue", 64'(mt_q.size()), 64'(1));
          else begin pend_mt_v = mt_q.pop_front(); pend_mt = 1'b1; end
        end else begin
          if (mf_q.size() == 0) chk("mf_queue", 64'(mf_q.size()), 64'(1));
          else chk("mf_data", 64'(bus.mf_data_o), 64'(mf_q.pop_front()));
        end
      end
      prev_busy = bus.busy_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] codes[8];
    logic [5:0] f;
    int sel;
    codes = '{FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
              FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    bus.issue_i = 1'b0;
    bus.funct_i = '0;
    bus.rs_i    = '0;
    bus.rt_i    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy_o), 64'(0));
    chk("reset_done", 64'(bus.done_o), 64'(0));
    chk("reset_hi", 64'(bus.hi_o), 64'(0));
    chk("reset_lo", 64'(bus.lo_o), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply (counter = 10)
    issue(FUNCT_MTHI, 32'h0000_ABCD, 32'h0);
    issue(FUNCT_MULT, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    mf_q.delete();
    mt_q.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("midop_reset_busy", 64'(bus.busy_o), 64'(0));
    chk("midop_reset_hi", 64'(bus.hi_o), 64'(0));
    chk("midop_reset_lo", 64'(bus.lo_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_reset_hi", 64'(bus.hi_o), 64'(0));
    chk("post_reset_lo", 64'(bus.lo_o), 64'(0));
    chk("post_reset_busy", 64'(bus.busy_o), 64'(0));

    // Directed: signed/unsigned ops, divide by zero, queued back-to-back
    issue(FUNCT_MULT, 32'hFFFF_FFFD, 32'd5);
    issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(FUNCT_DIVU, 32'd100, 32'd7);
    issue(FUNCT_DIV, 32'd5, 32'd0);
    issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    issue(FUNCT_MFHI, 32'h0, 32'h0);
    wait_idle();

    // MT while idle, then MT landing in a done cycle
    issue(FUNCT_MTLO, 32'h0000_1234, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("mtlo_no_busy", 64'(bus.busy_o), 64'(0));
    issue(FUNCT_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
    issue(FUNCT_MULT, 32'd12345, 32'hFFFF_FF00);
    issue(FUNCT_MTHI, 32'hDEAD_BEEF, 32'h0);
    issue(FUNCT_MFHI, 32'h0, 32'h0);
    issue(FUNCT_MFLO, 32'h0, 32'h0);
    wait_idle();

    // Randomized mix including non-HI/LO functs
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) f = codes[sel];
      else f = (sel == 8) ? 6'h21 : 6'h2a;
      issue(f, rnd_operand(), ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_operand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
    end
    wait_idle();

    chk("scoreboard_drain", 64'(exp_q.size() + mf_q.size() + mt_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
